// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the Hack screen path of the VGA subsystem.
//   HACK_W / HACK_H  : Hack screen size in pixels (512 x 256)
//   WORDS_PER_ROW    : 16-bit screen words per Hack row
//   HACK_WORDS       : total screen words (8K)
//   rgb444_t         : packed {R4,G4,B4} colour
//   DEF_*_RGB        : default foreground / background / border colours
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int HACK_W        = 512;
    localparam int HACK_H        = 256;
    localparam int WORDS_PER_ROW = 32;
    localparam int HACK_WORDS    = 8192;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t DEF_FG_RGB     = 12'h000;
    localparam rgb444_t DEF_BG_RGB     = 12'hFFF;
    localparam rgb444_t DEF_BORDER_RGB = 12'h333;

endpackage

// File: rtl/hack_word_shifter.sv
// -----------------------------------------------------------------------------
// hack_word_shifter
// 16-bit right-shift register serialising one Hack screen word, LSB first.
// On load the word's bit 0 is consumed by the caller in the same pixel, so the
// register keeps the word already shifted by one.
//   clk, reset : clock, synchronous active-high reset (clears the register)
//   load       : capture load_data >> 1
//   shift_en   : shift the register right by one (ignored when load is high)
//   load_data  : word to serialise
//   bit0       : current LSB, i.e. the next pixel to display
// -----------------------------------------------------------------------------
module hack_word_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        shift_en,
    input  logic [15:0] load_data,
    output logic        bit0
);

    logic [15:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 16'h0000;
        end else if (load) begin
            q <= load_data >> 1;
        end else if (shift_en) begin
            q <= q >> 1;
        end
    end

    assign bit0 = q[0];

endmodule

// File: rtl/hack_screen_renderer.sv
// -----------------------------------------------------------------------------
// hack_screen_renderer
// Pixel generator placed after the 640x480 VGA timing generator. Shows the
// 512x256 monochrome Hack screen in a window starting at (H_OFF, V_OFF); the
// rest of the active area is painted BORDER_RGB, blanking is black.
//   clk, reset          : clock, synchronous active-high reset
//   p_tick              : pixel strobe, high every second clk
//   video_on            : active-area flag of the current pixel
//   pixel_x, pixel_y    : current pixel coordinates
//   h_sync_in, v_sync_in: syncs from the timing generator
//   vram_rd_en          : screen RAM read strobe (combinational)
//   vram_addr           : screen RAM word address (combinational)
//   vram_rdata          : read data, valid exactly 1 clk after vram_rd_en
//   vga_rgb             : registered colour
//   vga_hsync/vga_vsync : registered syncs, aligned with vga_rgb
//
// Read port protocol: there is no back-pressure. A read issued with
// vram_rd_en on a tick clk returns vram_rdata on the following clk, which is
// always a non-tick clk, and is captured into fetch_buf there unconditionally.
// -----------------------------------------------------------------------------
module hack_screen_renderer
    import vga_pkg::*;
#(
    parameter int      H_OFF      = 64,
    parameter int      V_OFF      = 112,
    parameter rgb444_t FG_RGB     = DEF_FG_RGB,
    parameter rgb444_t BG_RGB     = DEF_BG_RGB,
    parameter rgb444_t BORDER_RGB = DEF_BORDER_RGB
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic        vram_rd_en,
    output logic [12:0] vram_addr,
    input  logic [15:0] vram_rdata,
    output logic [11:0] vga_rgb,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    // Window-local coordinates (two's complement; negative left/above window)
    logic [10:0] lx;
    logic [10:0] nx;
    logic [7:0]  ly_lo;
    logic        win_y;
    logic        win_x;
    logic        win;
    logic        nx_in_row;

    assign lx    = pixel_x - 11'(H_OFF);
    assign nx    = lx + 11'd1;
    assign ly_lo = pixel_y[7:0] - 8'(V_OFF);

    assign win_y = (pixel_y >= 11'(V_OFF)) && (pixel_y < 11'(V_OFF + HACK_H));
    assign win_x = (pixel_x >= 11'(H_OFF)) && (pixel_x < 11'(H_OFF + HACK_W));
    assign win   = video_on & win_y & win_x;

    // 0 <= nx < 512 in 11-bit two's complement: sign bit and bit 9 both clear
    assign nx_in_row = (nx[10:9] == 2'b00);

    // Prefetch the word one pixel before its first pixel is displayed
    assign vram_rd_en = ~reset & p_tick & win_y & nx_in_row & (nx[3:0] == 4'h0);
    assign vram_addr  = {ly_lo, nx[8:4]};

    // Capture stage
    logic        rd_pending;
    logic [15:0] fetch_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            fetch_buf  <= 16'h0000;
        end else begin
            rd_pending <= vram_rd_en;
            if (rd_pending) begin
                fetch_buf <= vram_rdata;
            end
        end
    end

    // Serialiser: a word boundary takes bit 0 straight from fetch_buf
    logic word_start;
    logic load;
    logic shift_en;
    logic shift_bit0;
    logic pix;

    assign word_start = (lx[3:0] == 4'h0);
    assign load       = p_tick & win & word_start;
    assign shift_en   = p_tick & win & ~word_start;

    hack_word_shifter u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (fetch_buf),
        .bit0      (shift_bit0)
    );

    assign pix = word_start ? fetch_buf[0] : shift_bit0;

    rgb444_t rgb_next;

    always_comb begin
        rgb_next = 12'h000;
        if (video_on) begin
            if (!win) begin
                rgb_next = BORDER_RGB;
            end else if (pix) begin
                rgb_next = FG_RGB;
            end else begin
                rgb_next = BG_RGB;
            end
        end
    end

    // Output stage: colour and syncs sampled on the same tick stay aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rgb   <= 12'h000;
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
        end else if (p_tick) begin
            vga_rgb   <= rgb_next;
            vga_hsync <= h_sync_in;
            vga_vsync <= v_sync_in;
        end
    end

endmodule

// File: tb/tb_hack_screen_renderer.sv
// -----------------------------------------------------------------------------
// tb_hack_screen_renderer
// Sweeps selected rows of the 640x480 frame (pixel tick every 2nd clk) against
// a screen RAM model filled with random words, and compares colour, syncs and
// read requests with a coordinate-based reference model.
// -----------------------------------------------------------------------------
module tb_hack_screen_renderer;

    localparam int H_OFF = 64;
    localparam int V_OFF = 112;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        vram_rd_en;
    logic [12:0] vram_addr;
    logic [15:0] vram_rdata;
    logic [11:0] vga_rgb;
    logic        vga_hsync;
    logic        vga_vsync;

    logic [15:0] mem [0:8191];

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    hack_screen_renderer #(
        .H_OFF (H_OFF),
        .V_OFF (V_OFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .vram_rd_en (vram_rd_en),
        .vram_addr  (vram_addr),
        .vram_rdata (vram_rdata),
        .vga_rgb    (vga_rgb),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync)
    );

    // Screen RAM: data valid 1 clk after a read, noise otherwise
    always @(posedge clk) begin
        if (vram_rd_en) vram_rdata <= mem[vram_addr];
        else            vram_rdata <= 16'($urandom);
    end

    // ---------------- reference model ----------------
    function automatic bit in_window(int x, int y);
        return (x >= H_OFF) && (x < H_OFF + 512) && (y >= V_OFF) && (y < V_OFF + 256);
    endfunction

    function automatic logic [11:0] ref_rgb(int x, int y);
        logic [15:0] w;
        if (!(x < 640 && y < 480)) return 12'h000;
        if (!in_window(x, y)) return 12'h333;
        w = mem[(y - V_OFF) * 32 + (x - H_OFF) / 16];
        return w[(x - H_OFF) % 16] ? 12'h000 : 12'hFFF;
    endfunction

    // A read is expected on the tick of the pixel just before each 16-pixel word
    function automatic bit ref_rd(int x, int y);
        int n;
        n = x + 1 - H_OFF;
        return (y >= V_OFF) && (y < V_OFF + 256) && (n >= 0) && (n < 512) && (n % 16 == 0);
    endfunction

    function automatic int ref_addr(int x, int y);
        return (y - V_OFF) * 32 + (x + 1 - H_OFF) / 16;
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s x=%0d y=%0d observed=%h expected=%h", tag, pixel_x, pixel_y, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left 1 time unit after a rising edge; one pixel = 2 clks.
    task automatic do_pixel(input int x, input int y, input bit chk_col);
        bit exp_hs, exp_vs;
        pixel_x   = 11'(x);
        pixel_y   = 11'(y);
        video_on  = (x < 640) && (y < 480);
        exp_hs    = !(x >= 656 && x < 752);
        exp_vs    = !(y >= 490 && y < 492);
        h_sync_in = exp_hs;
        v_sync_in = exp_vs;
        p_tick    = 1'b1;
        #1;
        chk("rd_en", 16'(vram_rd_en), 16'(ref_rd(x, y)));
        if (ref_rd(x, y)) chk("addr", 16'(vram_addr), 16'(ref_addr(x, y)));
        @(posedge clk); #1;
        if (chk_col) chk("rgb", 16'(vga_rgb), 16'(ref_rgb(x, y)));
        chk("hsync", 16'(vga_hsync), 16'(exp_hs));
        chk("vsync", 16'(vga_vsync), 16'(exp_vs));
        p_tick = 1'b0;
        #1;
        chk("rd_en_idle", 16'(vram_rd_en), 16'h0);
        @(posedge clk); #1;
        if (chk_col) chk("rgb_hold", 16'(vga_rgb), 16'(ref_rgb(x, y)));
    endtask

    task automatic reset_clk(input bit tick);
        p_tick = tick;
        #1;
        chk("rd_en_rst", 16'(vram_rd_en), 16'h0);
        @(posedge clk); #1;
        chk("rgb_rst", 16'(vga_rgb), 16'h0);
        chk("hsync_rst", 16'(vga_hsync), 16'h0);
        chk("vsync_rst", 16'(vga_vsync), 16'h0);
    endtask

    // Sweep one row; optionally pulse reset for 3 clks after pixel reset_at.
    // Colour of the interrupted row is not defined after the reset.
    task automatic sweep_row(input int y, input int x0, input int x1, input int reset_at);
        bit col_ok;
        col_ok = 1'b1;
        for (int x = x0; x <= x1; x++) begin
            do_pixel(x, y, col_ok);
            if (x == reset_at) begin
                reset = 1'b1;
                reset_clk(1'b0);
                reset_clk(1'b1);
                reset_clk(1'b0);
                reset = 1'b0;
                col_ok = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        // First Hack row: single bits to pin down bit order and word order
        mem[0] = 16'h0001;
        mem[1] = 16'h8000;
        for (int i = 2; i < 32; i++) mem[i] = 16'h0000;

        reset     = 1'b1;
        p_tick    = 1'b0;
        video_on  = 1'b0;
        pixel_x   = 11'd0;
        pixel_y   = 11'd0;
        h_sync_in = 1'b1;
        v_sync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rgb_init", 16'(vga_rgb), 16'h0);
        chk("hsync_init", 16'(vga_hsync), 16'h0);
        chk("vsync_init", 16'(vga_vsync), 16'h0);
        chk("rd_en_init", 16'(vram_rd_en), 16'h0);
        reset = 1'b0;

        // Border row above the window: no memory traffic, border colour
        sweep_row(100, 50, 600, -1);
        // First window row across the whole line including sync region
        sweep_row(112, 0, 799, -1);
        sweep_row(113, 55, 600, -1);
        for (int r = 0; r < 3; r++) sweep_row(int'($urandom_range(114, 366)), 55, 600, -1);
        // Last window row: final fetch of word 8191 at x = 559
        sweep_row(367, 55, 600, -1);
        // Mid-row reset, then the next row must be rendered cleanly
        sweep_row(200, 55, 320, 300);
        sweep_row(201, 55, 600, -1);
        // Vertical blanking with vsync active
        sweep_row(489, 640, 660, -1);
        sweep_row(490, 90, 110, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_screen_renderer.md
Name: hack_screen_renderer

Overview:
Pixel generator directly downstream of the VGA timing generator (640x480, pixel tick every 2nd clk).
- Maps the 512x256 monochrome Hack screen memory (8K x 16-bit words) into a centred window of the 640x480 frame.
- Fetches one word per 16 pixels from a dedicated synchronous read port of screen RAM, then shifts the bits out one per pixel.
- Drives registered RGB444 plus hsync/vsync, all aligned to the same pixel.

Parameters:
H_OFF, 64, first display column of the Hack window (must be >=1)
V_OFF, 112, first display row of the Hack window
FG_RGB, 12'h000, colour for Hack bit = 1 (black)
BG_RGB, 12'hFFF, colour for Hack bit = 0 (white)
BORDER_RGB, 12'h333, colour inside the active area but outside the window

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
p_tick  in  1  pixel-tick strobe from the timing generator, high every 2nd clk
video_on  in  1  active-area flag for the current pixel
pixel_x  in  11  current column
pixel_y  in  11  current row
h_sync_in  in  1  horizontal sync from the timing generator
v_sync_in  in  1  vertical sync from the timing generator
vram_rd_en  out  1  screen RAM read strobe (combinational)
vram_addr  out  13  screen RAM word address (combinational)
vram_rdata  in  16  read data, valid exactly 1 clk after vram_rd_en
vga_rgb  out  12  registered colour {R4,G4,B4}
vga_hsync  out  1  registered, aligned to vga_rgb
vga_vsync  out  1  registered, aligned to vga_rgb

Behaviour:
- Reset: vga_rgb = 0, vga_hsync = 0, vga_vsync = 0, fetch_buf = 0, shift_reg = 0, rd_pending = 0. vram_rd_en is forced 0 while reset is high.
- Local coordinates: lx = pixel_x - H_OFF, ly = pixel_y - V_OFF, 11-bit two's complement.
- Window membership:
  - win_y = pixel_y in [V_OFF, V_OFF+256).
  - win = video_on & win_y & pixel_x in [H_OFF, H_OFF+512).
- Prefetch:
  - nx = lx + 1.
  - vram_rd_en = p_tick & win_y & (0 <= nx < 512) & (nx[3:0] == 0).
  - vram_addr = {ly[7:0], nx[8:4]}, i.e. ly*32 + nx/16.
  - A word is therefore requested on the tick one pixel before its first pixel. The first request of a row is at pixel_x = H_OFF-1.
- Capture:
  - rd_pending <= vram_rd_en.
  - When rd_pending = 1, fetch_buf <= vram_rdata. This is always the non-tick clk between the two ticks.
- Output stage, updated only on clks with p_tick = 1; outputs hold otherwise, so each value lasts 2 clks:
  - win & lx[3:0] == 0: pix = fetch_buf[0]; shift_reg <= fetch_buf >> 1.
  - win & lx[3:0] != 0: pix = shift_reg[0]; shift_reg <= shift_reg >> 1.
  - Bit order: LSB is the leftmost pixel (Hack convention).
  - vga_rgb <= !video_on ? 0 : (!win ? BORDER_RGB : (pix ? FG_RGB : BG_RGB)).
  - vga_hsync <= h_sync_in; vga_vsync <= v_sync_in. Both are sampled on the same tick as pixel_x/pixel_y, so the syncs stay aligned with colour.
- Latency: colour for pixel (x,y) appears 1 clk after the p_tick clk that presents (x,y).
- Boundaries:
  - No fetch at nx = 512 (last window column).
  - Row 255 reads words 8160..8191; addresses never exceed 8191.
  - No fetch outside win_y; the border gets no memory traffic.
- Reset mid-frame: pipeline state is cleared. Output resumes correctly from the next row start, since every row's first word is prefetched at H_OFF-1. Remaining pixels of an interrupted row may show stale/zero data but never corrupt later rows.
- Simultaneous capture and output load never occur on the same clk: capture happens on non-tick clks, loads on tick clks.

Decomposition:
- Shared package vga_pkg holds:
  - HACK_W = 512, HACK_H = 256, WORDS_PER_ROW = 32, HACK_WORDS = 8192
  - typedef rgb444_t (12-bit)
  - default colour constants
- One natural sub-module, hack_word_shifter: 16-bit load/shift-right register with load, shift_en and bit0 output.

Test Plan:
1. Word 0 = 16'h0001, others 0 -> vram_rd_en with addr 0 at (63,112); vga_rgb = 12'h000 for pixel 64 and 12'hFFF for pixels 65..79.
2. Row addressing: pixel_y = 113 -> fetch at x = 63 has addr 32. Pixel_y = 367 -> last fetch of the row, at x = 559, has addr 8191. No rd_en at x = 575.
3. Bit order: word 1 = 16'h8000 -> only pixel x = 95 is FG; the fetch of addr 1 occurs at x = 79.
4. Border/blank: (10,200) -> 12'h333; (700,200) and (100,490) -> 12'h000; no rd_en asserted anywhere outside rows 112..367.
5. Sync alignment: h_sync_in toggles at x = 656 -> vga_hsync changes on the same clk edge as the vga_rgb of x = 656; vga_vsync behaves likewise.
6. Assert reset for 3 clks at (300,200) -> all outputs 0 during reset; row 201 renders correct words 0x..., first fetch addr 89*32 at x = 63.
